sm_product_accum: RTL and testbench

- Downstream stage of the 4-bit sign-magnitude multiplier in the approximate DNN datapath.
- Consumes the multiplier's 8-bit product magnitude and sign bit, and accumulates a frame of products (one neuron dot-product) into a saturating signed accumulator.
- Applies optional ReLU, clips the result to a signed activation width, and presents it on a valid/ready output.

---
 rtl/sm_product_accum.sv | 124 ++++++++++++
 tb/tb_sm_product_accum.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sm_product_accum.sv
// Accumulates a frame of sign-magnitude products into a saturating signed sum,
// then applies optional ReLU and clips to the output activation width.
//
// state | meaning
// IDLE  | no beat accepted yet in this frame
// ACC   | at least one beat accepted, waiting for the last one
// OUT   | result presented, waiting for the consumer handshake
module sm_product_accum #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int OUT_W  = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_mag,
    input  logic              in_sign,
    input  logic              in_last,
    input  logic              relu_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  term_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    state_t state, state_nxt;

    logic [ACC_W-1:0]     acc;
    logic                 ovf_flag;
    logic [ACC_W-1:0]     mag_ext;
    logic [ACC_W-1:0]     term;
    logic [ACC_W:0]       sum_wide;
    logic                 sat;
    logic [ACC_W-1:0]     sat_sum;
    logic [ACC_W-1:0]     relu_val;
    logic [ACC_W-OUT_W:0] hi_bits;
    logic                 fits;
    logic [OUT_W-1:0]     clip_val;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 accept;
    logic                 handshake;

    assign in_ready  = (state != S_OUT);
    assign out_valid = (state == S_OUT);
    assign out_ovf   = ovf_flag;
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    // Add one bit of headroom; disagreement of the top two bits means overflow.
    assign mag_ext  = {{(ACC_W-PROD_W){1'b0}}, in_mag};
    assign term     = in_sign ? (~mag_ext + 1'b1) : mag_ext;
    assign sum_wide = {acc[ACC_W-1], acc} + {term[ACC_W-1], term};
    assign sat      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign sat_sum  = sat ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];

    assign relu_val = (relu_en && sat_sum[ACC_W-1]) ? '0 : sat_sum;
    assign hi_bits  = relu_val[ACC_W-1:OUT_W-1];
    assign fits     = (&hi_bits) || !(|hi_bits);
    assign clip_val = fits ? relu_val[OUT_W-1:0] : (relu_val[ACC_W-1] ? OUT_MIN : OUT_MAX);

    assign cnt_inc = (&term_cnt) ? term_cnt : term_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ACC: begin
                if (accept) begin
                    state_nxt = in_last ? S_OUT : S_ACC;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            ovf_flag <= 1'b0;
            out_data <= '0;
            term_cnt <= '0;
        end else if (accept) begin
            term_cnt <= cnt_inc;
            if (in_last) begin
                acc      <= '0;
                out_data <= clip_val;
                ovf_flag <= ovf_flag || sat || !fits;
            end else begin
                acc      <= sat_sum;
                ovf_flag <= ovf_flag || sat;
            end
        end else if (handshake) begin
            term_cnt <= '0;
            ovf_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sm_product_accum.sv
// Directed bench for sm_product_accum: stimulus pushes hand-computed results
// into a scoreboard queue, a monitor pops them on each output handshake.
module tb_sm_product_accum;

    typedef struct packed {
        logic [7:0] data;
        logic       ovf;
        logic [7:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_mag;
    logic       in_sign;
    logic       in_last;
    logic       relu_en;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;
    logic [7:0] term_cnt;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    sm_product_accum #(
        .PROD_W(8),
        .ACC_W (16),
        .OUT_W (8),
        .CNT_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mag   (in_mag),
        .in_sign  (in_sign),
        .in_last  (in_last),
        .relu_en  (relu_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf),
        .term_cnt (term_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic o, input logic [7:0] c);
        exp_t e;
        e.data = d;
        e.ovf  = o;
        e.cnt  = c;
        sb.push_back(e);
    endtask

    // Drives a beat and returns after the edge that accepts it; n = edges waited.
    task automatic send(input logic [7:0] mag, input logic sgn, input logic last,
                        input logic relu, output int n);
        logic ok;
        logic done;
        in_valid = 1'b1;
        in_mag   = mag;
        in_sign  = sgn;
        in_last  = last;
        relu_en  = relu;
        n        = 0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            n++;
            if (ok) begin
                done = 1'b1;
            end else if (n >= 50) begin
                chk("send_timeout", 32'(n), 32'd0);
                done = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_ovf",  32'(out_ovf),  32'(e.ovf));
                chk("term_cnt", 32'(term_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        int n;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_mag    = '0;
        in_sign   = 1'b0;
        in_last   = 1'b0;
        relu_en   = 1'b0;
        out_ready = 1'b1;

        // Asynchronous reset with no clock edge yet
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_ovf",   32'(out_ovf),   32'd0);
        chk("rst_term_cnt",  32'(term_cnt),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        cycles(2);
        rst_n = 1'b1;
        cycles(1);

        // Basic frame: 3 - 5 + 16 = 14
        send(8'h03, 1'b0, 1'b0, 1'b0, n);
        send(8'h05, 1'b1, 1'b0, 1'b0, n);
        chk("basic_no_early_valid", 32'(out_valid), 32'd0);
        push(8'h0E, 1'b0, 8'd3);
        send(8'h10, 1'b0, 1'b1, 1'b0, n);
        idle();
        chk("basic_latency_valid", 32'(out_valid), 32'd1);
        chk("basic_in_ready_low",  32'(in_ready),  32'd0);
        cycles(1);
        chk("basic_valid_falls", 32'(out_valid), 32'd0);
        chk("basic_data_kept",   32'(out_data),  32'h0E);
        cycles(1);

        // 3 - 180 + 12 = -165: clips to -128 without ReLU, zero with ReLU
        push(8'h80, 1'b1, 8'd3);
        send(8'd3,   1'b0, 1'b0, 1'b0, n);
        send(8'd180, 1'b1, 1'b0, 1'b0, n);
        send(8'd12,  1'b0, 1'b1, 1'b0, n);
        idle();
        cycles(2);
        push(8'h00, 1'b0, 8'd3);
        send(8'd3,   1'b0, 1'b0, 1'b1, n);
        send(8'd180, 1'b1, 1'b0, 1'b1, n);
        send(8'd12,  1'b0, 1'b1, 1'b1, n);
        idle();
        cycles(2);

        // Backpressure with a pending beat
        out_ready = 1'b0;
        push(8'h01, 1'b0, 8'd1);
        send(8'd1, 1'b0, 1'b1, 1'b0, n);
        in_mag  = 8'd7;
        in_sign = 1'b0;
        in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready),  32'd0);
            chk("bp_out_data", 32'(out_data),  32'h01);
            chk("bp_valid",    32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'd7, 1'b0, 1'b0, 1'b0, n);
        chk("bp_accept_delay", 32'(n), 32'd2);
        chk("bp_fresh_cnt",    32'(term_cnt), 32'd1);
        push(8'h07, 1'b0, 8'd2);
        send(8'd0, 1'b0, 1'b1, 1'b0, n);
        idle();
        cycles(2);

        // 200 x 225 = 45000 pins the accumulator at 32767
        push(8'h7F, 1'b1, 8'd200);
        for (int i = 0; i < 199; i++) begin
            send(8'd225, 1'b0, 1'b0, 1'b0, n);
        end
        chk("sat_acc_pinned", 32'(dut.acc), 32'd32767);
        send(8'd225, 1'b0, 1'b1, 1'b0, n);
        idle();
        cycles(2);

        // Negative zero single-beat frame
        push(8'h00, 1'b0, 8'd1);
        send(8'd0, 1'b1, 1'b1, 1'b0, n);
        idle();
        cycles(2);

        // Reset mid-frame discards the partial sum
        send(8'd50, 1'b0, 1'b0, 1'b0, n);
        send(8'd50, 1'b0, 1'b0, 1'b0, n);
        idle();
        rst_n = 1'b0;
        #1;
        chk("midrst_term_cnt", 32'(term_cnt), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(1);
        push(8'h01, 1'b0, 8'd1);
        send(8'd1, 1'b0, 1'b1, 1'b0, n);
        idle();

        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
